// File: rtl/clk_div_prog.sv
// Runtime-programmable clock divider / clock-enable generator with shadowed divisor/mode updates.
// Updates are committed only at a period boundary, so clk_out never glitches; registered outputs.
module clk_div_prog #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned DIV_RESET  = 4,
  parameter logic        MODE_RESET = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div_in,
  input  logic             mode_in,
  output logic             load_ack,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PEND = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] shadow_div_q, shadow_div_d;
  logic             shadow_mode_q, shadow_mode_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             ack_q, ack_d;

  logic             tc;
  logic             is_pend;
  logic             commit;
  logic [CNT_W-1:0] commit_div;
  logic             commit_mode;

  assign tc      = (cnt_q == div_q);
  assign is_pend = (state_q == ST_PEND);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    div_d         = div_q;
    mode_d        = mode_q;
    shadow_div_d  = shadow_div_q;
    shadow_mode_d = shadow_mode_q;
    clk_out_d     = clk_out_q;
    tick_d        = 1'b0;
    ack_d         = 1'b0;
    commit        = 1'b0;
    commit_div    = shadow_div_q;
    commit_mode   = shadow_mode_q;

    if (!en) begin
      // A pending shadow survives a pause and still waits for a terminal count.
      state_d = is_pend ? ST_PEND : ST_STOP;
      if (mode_q) begin
        clk_out_d = 1'b0;
      end
      if (load) begin
        commit      = 1'b1;
        commit_div  = div_in;
        commit_mode = mode_in;
        state_d     = ST_STOP;
      end
    end else begin
      cnt_d     = tc ? '0 : cnt_q + CNT_W'(1);
      tick_d    = tc;
      clk_out_d = mode_q ? tc : (tc ? ~clk_out_q : clk_out_q);
      state_d   = is_pend ? ST_PEND : ST_RUN;
      if (is_pend && tc) begin
        commit  = 1'b1;
        state_d = ST_RUN;
      end
      if (load) begin
        shadow_div_d  = div_in;
        shadow_mode_d = mode_in;
        state_d       = ST_PEND;
      end
    end

    if (commit) begin
      div_d  = commit_div;
      mode_d = commit_mode;
      cnt_d  = '0;
      ack_d  = 1'b1;
      if (commit_mode != mode_q) begin
        clk_out_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_STOP;
      cnt_q         <= '0;
      div_q         <= CNT_W'(DIV_RESET);
      mode_q        <= MODE_RESET;
      shadow_div_q  <= '0;
      shadow_mode_q <= 1'b0;
      clk_out_q     <= 1'b0;
      tick_q        <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      div_q         <= div_d;
      mode_q        <= mode_d;
      shadow_div_q  <= shadow_div_d;
      shadow_mode_q <= shadow_mode_d;
      clk_out_q     <= clk_out_d;
      tick_q        <= tick_d;
      ack_q         <= ack_d;
    end
  end

  assign cnt      = cnt_q;
  assign clk_out  = clk_out_q;
  assign tick     = tick_q;
  assign load_ack = ack_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: hand-computed count/output sequences around loads, pauses and reset.
module tb_clk_div_prog;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [7:0] div_in;
  logic       mode_in;
  logic       load_ack;
  logic       clk_out;
  logic       tick;
  logic [7:0] cnt;

  int checks = 0;
  int errors = 0;
  int acc;
  int acc2;
  int held;

  clk_div_prog #(.CNT_W(8), .DIV_RESET(4), .MODE_RESET(1'b0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .div_in   (div_in),
    .mode_in  (mode_in),
    .load_ack (load_ack),
    .clk_out  (clk_out),
    .tick     (tick),
    .cnt      (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, need finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; div_in = 8'd0; mode_in = 1'b0;
    #12;
    check("rst_cnt", int'(cnt), 0);
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_ack", int'(load_ack), 0);

    // 1: default divide-by-10 toggle
    rst_n = 1'b1; en = 1'b1;
    repeat (4) step();
    check("t1_cnt4", int'(cnt), 4);
    check("t1_clk_pre", int'(clk_out), 0);
    check("t1_tick_pre", int'(tick), 0);
    step();
    check("t1_first_tc_cnt", int'(cnt), 0);
    check("t1_first_tick", int'(tick), 1);
    check("t1_first_rise", int'(clk_out), 1);
    acc = 0; acc2 = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      acc  += int'(clk_out);
      acc2 += int'(tick);
    end
    check("t1_high_in_20", acc, 10);
    check("t1_ticks_in_20", acc2, 4);

    // 5: pause at cnt=3 (cnt=0, clk_out=1 here)
    repeat (3) step();
    check("t5_cnt3", int'(cnt), 3);
    en = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cnt !== 8'd3 || tick !== 1'b0 || clk_out !== 1'b1) acc++;
    end
    check("t5_hold_bad", acc, 0);
    en = 1'b1;
    step();
    check("t5_resume_cnt", int'(cnt), 4);
    check("t5_resume_tick", int'(tick), 0);
    step();
    check("t5_tc_tick", int'(tick), 1);
    check("t5_tc_clk", int'(clk_out), 0);

    // 2: pulse mode loaded in STOP
    en = 1'b0; load = 1'b1; div_in = 8'd2; mode_in = 1'b1;
    step();
    check("t2_ack", int'(load_ack), 1);
    check("t2_cnt0", int'(cnt), 0);
    check("t2_clk0", int'(clk_out), 0);
    load = 1'b0; en = 1'b1;
    step();
    check("t2_ack_drop", int'(load_ack), 0);
    check("t2_cnt1", int'(cnt), 1);
    acc = 0; acc2 = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      acc += int'(clk_out);
      if (clk_out !== tick) acc2++;
    end
    check("t2_pulses_in_8", acc, 3);
    check("t2_clk_ne_tick", acc2, 0);
    check("t2_end_cnt", int'(cnt), 0);

    // 3: back to toggle div 4, then reload 1 at cnt=2
    en = 1'b0; load = 1'b1; div_in = 8'd4; mode_in = 1'b0;
    step();
    check("t3_clk_mode_change", int'(clk_out), 0);
    load = 1'b0; en = 1'b1;
    repeat (2) step();
    check("t3_cnt2", int'(cnt), 2);
    load = 1'b1; div_in = 8'd1;
    step();
    load = 1'b0;
    check("t3_cnt3", int'(cnt), 3);
    check("t3_no_early_ack", int'(load_ack), 0);
    step();
    check("t3_cnt4", int'(cnt), 4);
    step();
    check("t3_commit_cnt", int'(cnt), 0);
    check("t3_commit_ack", int'(load_ack), 1);
    check("t3_commit_clk", int'(clk_out), 1);
    step();
    check("t3_cnt1", int'(cnt), 1);
    check("t3_ack_drop", int'(load_ack), 0);
    step();
    check("t3_tc2_cnt", int'(cnt), 0);
    check("t3_tc2_clk", int'(clk_out), 0);
    repeat (2) step();
    check("t3_tc3_clk", int'(clk_out), 1);

    // 4: last load wins while pending; div 5 first via STOP
    en = 1'b0; load = 1'b1; div_in = 8'd5; mode_in = 1'b0;
    step();
    check("t4_stop_ack", int'(load_ack), 1);
    en = 1'b1; div_in = 8'd7;
    step();
    div_in = 8'd3;
    step();
    load = 1'b0;
    check("t4_cnt2", int'(cnt), 2);
    acc = 0; acc2 = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      acc += int'(load_ack);
      if (i >= 4 && int'(cnt) > acc2) acc2 = int'(cnt);
    end
    check("t4_ack_count", acc, 1);
    check("t4_max_cnt_after", acc2, 3);
    check("t4_end_cnt", int'(cnt), 0);

    // 6: reset while a load of 9 is pending
    load = 1'b1; div_in = 8'd9;
    step();
    load = 1'b0;
    check("t6_pend_cnt", int'(cnt), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_cnt", int'(cnt), 0);
    check("t6_rst_clk", int'(clk_out), 0);
    rst_n = 1'b1;
    acc = 0;
    held = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      acc += int'(load_ack);
      if (i == 3) held = int'(cnt);
      if (i == 4) check("t6_first_tc_clk", int'(clk_out), 1);
    end
    check("t6_cnt_before_tc", held, 4);
    check("t6_no_ack", acc, 0);
    check("t6_second_tc_tick", int'(tick), 1);
    check("t6_second_tc_clk", int'(clk_out), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
